// File: rtl/line_burst_responder_pkg.sv
// Shared types and constants for the pmem line-to-burst responder.
package line_burst_responder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD   = 2'd1,
      WR   = 2'd2,
      DONE = 2'd3
   } burst_state_e;

   localparam int lbr_burst_width = 64;
   localparam int lbr_num_beats   = 4;

endpackage

// File: rtl/line_burst_responder_burst_beat_reg.sv
// burst_beat_reg: line register with whole-line load, per-beat write and beat select mux.
module burst_beat_reg #(
   parameter int width       = 256,
   parameter int burst_width = 64,
   parameter int sel_w       = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   load,
   input  logic [width-1:0]       load_line,
   input  logic                   beat_we,
   input  logic [sel_w-1:0]       beat_sel,
   input  logic [burst_width-1:0] beat_in,
   input  logic [sel_w-1:0]       rd_sel,
   output logic [burst_width-1:0] beat_out,
   output logic [width-1:0]       line_next
);

   logic [width-1:0] line_r;

   // next line value: whole-line load has priority over a single beat write
   always_comb begin
      line_next = line_r;
      if (load) begin
         line_next = load_line;
      end else if (beat_we) begin
         line_next[beat_sel*burst_width +: burst_width] = beat_in;
      end else begin
         line_next = line_r;
      end
   end

   // line storage, cleared on reset so a partial line never survives
   always_ff @(posedge clk) begin
      if (rst) begin
         line_r <= {width{1'b0}};
      end else begin
         line_r <= line_next;
      end
   end

   assign beat_out = line_r[rd_sel*burst_width +: burst_width];

endmodule

// File: rtl/line_burst_responder.sv
// line_burst_responder: serves one pmem line read/write as a little-endian beat burst.
// Define LINE_BUFFER_HIT_EN to answer repeat reads of the last fetched line without a burst.
module line_burst_responder
   import line_burst_responder_pkg::*;
#(
   parameter int width       = lbr_burst_width * lbr_num_beats,
   parameter int burst_width = lbr_burst_width,
   parameter int s_offset    = 5
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   pmem_read,
   input  logic                   pmem_write,
   input  logic [31:0]            pmem_address,
   input  logic [width-1:0]       pmem_wdata,
   output logic [width-1:0]       pmem_rdata,
   output logic                   pmem_resp,
   input  logic [burst_width-1:0] burst_in,
   output logic [burst_width-1:0] burst_out,
   output logic [31:0]            mem_address,
   output logic                   mem_read,
   output logic                   mem_write,
   input  logic                   mem_resp
);

   localparam int num_beats = width / burst_width;
   localparam int cnt_w     = (num_beats > 1) ? $clog2(num_beats) : 1;
   localparam logic [cnt_w-1:0] last_beat = cnt_w'(num_beats - 1);
   localparam logic [cnt_w-1:0] cnt_one   = cnt_w'(1);

   burst_state_e           state_r, state_s;
   logic [cnt_w-1:0]       count_r, count_s, rd_sel_s;
   logic [31:0]            mem_address_r, addr_s, aligned_s;
   logic                   mem_read_r, mem_read_s;
   logic                   mem_write_r, mem_write_s;
   logic                   pmem_resp_r, pmem_resp_s;
   logic [burst_width-1:0] burst_out_r, burst_out_s, beat_out_s;
   logic [width-1:0]       pmem_rdata_r, line_next_s;
   logic                   line_load_s, beat_we_s, rd_done_s, hit_s;
   logic                   unused_addr_s;

   assign aligned_s     = {pmem_address[31:s_offset], {s_offset{1'b0}}};
   assign unused_addr_s = ^pmem_address[s_offset-1:0];
   // next write beat is staged one beat ahead so burst_out stays registered
   assign rd_sel_s      = count_r + cnt_one;

   burst_beat_reg #(
      .width       (width),
      .burst_width (burst_width),
      .sel_w       (cnt_w)
   ) u_line (
      .clk       (clk),
      .rst       (rst),
      .load      (line_load_s),
      .load_line (pmem_wdata),
      .beat_we   (beat_we_s),
      .beat_sel  (count_r),
      .beat_in   (burst_in),
      .rd_sel    (rd_sel_s),
      .beat_out  (beat_out_s),
      .line_next (line_next_s)
   );

`ifdef LINE_BUFFER_HIT_EN
   logic                buf_valid_r;
   logic [31-s_offset:0] buf_addr_r;

   assign hit_s = buf_valid_r && (buf_addr_r == pmem_address[31:s_offset]);

   // remembers the last line fetched; any accepted write may alias it, so it drops validity
   always_ff @(posedge clk) begin
      if (rst) begin
         buf_valid_r <= 1'b0;
         buf_addr_r  <= {(32-s_offset){1'b0}};
      end else if ((state_r == IDLE) && pmem_write) begin
         buf_valid_r <= 1'b0;
      end else if (rd_done_s) begin
         buf_valid_r <= 1'b1;
         buf_addr_r  <= mem_address_r[31:s_offset];
      end else begin
         buf_valid_r <= buf_valid_r;
      end
   end
`else
   assign hit_s = 1'b0;
`endif

   // next-state and next registered-output values
   always_comb begin
      state_s     = state_r;
      count_s     = count_r;
      addr_s      = mem_address_r;
      mem_read_s  = 1'b0;
      mem_write_s = 1'b0;
      pmem_resp_s = 1'b0;
      burst_out_s = {burst_width{1'b0}};
      line_load_s = 1'b0;
      beat_we_s   = 1'b0;
      rd_done_s   = 1'b0;
      case (state_r)
         IDLE: begin
            count_s = {cnt_w{1'b0}};
            if (pmem_write) begin
               state_s     = WR;
               addr_s      = aligned_s;
               line_load_s = 1'b1;
               mem_write_s = 1'b1;
               burst_out_s = pmem_wdata[burst_width-1:0];
            end else if (pmem_read && hit_s) begin
               state_s     = DONE;
               pmem_resp_s = 1'b1;
            end else if (pmem_read) begin
               state_s    = RD;
               addr_s     = aligned_s;
               mem_read_s = 1'b1;
            end else begin
               state_s = IDLE;
            end
         end
         RD: begin
            mem_read_s = 1'b1;
            if (mem_resp) begin
               beat_we_s = 1'b1;
               if (count_r == last_beat) begin
                  state_s     = DONE;
                  mem_read_s  = 1'b0;
                  pmem_resp_s = 1'b1;
                  rd_done_s   = 1'b1;
               end else begin
                  count_s = count_r + cnt_one;
               end
            end else begin
               count_s = count_r;
            end
         end
         WR: begin
            mem_write_s = 1'b1;
            burst_out_s = burst_out_r;
            if (mem_resp) begin
               if (count_r == last_beat) begin
                  state_s     = DONE;
                  mem_write_s = 1'b0;
                  pmem_resp_s = 1'b1;
                  burst_out_s = {burst_width{1'b0}};
               end else begin
                  count_s     = count_r + cnt_one;
                  burst_out_s = beat_out_s;
               end
            end else begin
               count_s = count_r;
            end
         end
         DONE: begin
            state_s = IDLE;
            count_s = {cnt_w{1'b0}};
         end
         default: begin
            state_s = IDLE;
            count_s = {cnt_w{1'b0}};
         end
      endcase
   end

   // state register and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r       <= IDLE;
         count_r       <= {cnt_w{1'b0}};
         mem_address_r <= 32'h0000_0000;
         mem_read_r    <= 1'b0;
         mem_write_r   <= 1'b0;
         pmem_resp_r   <= 1'b0;
         burst_out_r   <= {burst_width{1'b0}};
         pmem_rdata_r  <= {width{1'b0}};
      end else begin
         state_r       <= state_s;
         count_r       <= count_s;
         mem_address_r <= addr_s;
         mem_read_r    <= mem_read_s;
         mem_write_r   <= mem_write_s;
         pmem_resp_r   <= pmem_resp_s;
         burst_out_r   <= burst_out_s;
         if (rd_done_s) begin
            pmem_rdata_r <= line_next_s;
         end else begin
            pmem_rdata_r <= pmem_rdata_r;
         end
      end
   end

   assign pmem_rdata  = pmem_rdata_r;
   assign pmem_resp   = pmem_resp_r;
   assign burst_out   = burst_out_r;
   assign mem_address = mem_address_r;
   assign mem_read    = mem_read_r;
   assign mem_write   = mem_write_r;

endmodule

// File: tb/tb_line_burst_responder.sv
// Self-checking bench for line_burst_responder: memory/line-buffer reference model plus random traffic.
module tb_line_burst_responder;

`ifdef LINE_BUFFER_HIT_EN
   localparam bit hit_en = 1'b1;
`else
   localparam bit hit_en = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst, pmem_read, pmem_write, pmem_resp, mem_read, mem_write, mem_resp;
   logic [31:0]  pmem_address, mem_address;
   logic [255:0] pmem_wdata, pmem_rdata;
   logic [63:0]  burst_in, burst_out;

   int checks = 0;
   int errors = 0;

   // reference state: memory contents per line, and the responder's reusable read line
   logic [255:0] mem_m [logic [26:0]];
   bit           buf_v;
   logic [26:0]  buf_a;

   line_burst_responder dut (
      .clk(clk), .rst(rst), .pmem_read(pmem_read), .pmem_write(pmem_write),
      .pmem_address(pmem_address), .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata),
      .pmem_resp(pmem_resp), .burst_in(burst_in), .burst_out(burst_out),
      .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
      .mem_resp(mem_resp)
   );

   always #5 clk = ~clk;

   function automatic logic [255:0] rand_line();
      logic [255:0] l;
      for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom();
      return l;
   endfunction

   function automatic logic [255:0] get_line(input logic [31:0] a);
      if (!mem_m.exists(a[31:5])) mem_m[a[31:5]] = rand_line();
      return mem_m[a[31:5]];
   endfunction

   function automatic bit exp_hit(input logic [31:0] a);
      return hit_en && buf_v && (buf_a == a[31:5]);
   endfunction

   // plays the burst memory until pmem_resp; mode 0 every cycle, 1 every other cycle, 2 random
   task automatic serve(input int mode, input logic [255:0] rd_line, input logic [31:0] exp_addr,
                        input bit keep_read, output int lat, output int nbeats,
                        output logic [255:0] cap, output int rd_cyc, output int wr_cyc,
                        output bit addr_ok, output int last_k);
      bit go;
      lat = -1; nbeats = 0; cap = '0; rd_cyc = 0; wr_cyc = 0; addr_ok = 1'b1; last_k = 0;
      for (int k = 1; k <= 80; k++) begin
         @(posedge clk); #1;
         mem_resp = 1'b0;
         if (pmem_resp) begin
            lat = k;
            pmem_write = 1'b0;
            if (!keep_read) pmem_read = 1'b0;
            break;
         end
         if (mem_read) rd_cyc++;
         if (mem_write) wr_cyc++;
         if (mem_read || mem_write) begin
            if (mem_address !== exp_addr) addr_ok = 1'b0;
            case (mode)
               0: go = 1'b1;
               1: go = (k % 2 == 0);
               default: go = ($urandom_range(0, 1) == 1);
            endcase
            if (go) begin
               mem_resp = 1'b1;
               if (nbeats < 4) begin
                  burst_in = rd_line[nbeats*64 +: 64];
                  if (mem_write) cap[nbeats*64 +: 64] = burst_out;
               end
               nbeats++;
               last_k = k;
            end
         end
      end
      pmem_write = 1'b0;
      if (!keep_read) pmem_read = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; pmem_read = 1'b0; pmem_write = 1'b0; pmem_address = '0;
      pmem_wdata = '0; burst_in = '0; mem_resp = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if ({pmem_resp, mem_read, mem_write} !== 3'b000) begin errors++;
         $display("FAIL reset_ctrl got %b exp 000", {pmem_resp, mem_read, mem_write}); end
      checks++; if (mem_address !== 32'h0) begin errors++;
         $display("FAIL reset_addr got %h exp 0", mem_address); end
      checks++; if (burst_out !== 64'h0) begin errors++;
         $display("FAIL reset_burst_out got %h exp 0", burst_out); end
      checks++; if (pmem_rdata !== 256'h0) begin errors++;
         $display("FAIL reset_rdata got %h exp 0", pmem_rdata); end
      rst = 1'b0;
      buf_v = 1'b0;
   endtask

   task automatic test_read_basic();
      int lat, nb, rc, wc, lk; bit aok; logic [255:0] cap, l;
      l = {{4{16'h4444}}, {4{16'h3333}}, {4{16'h2222}}, {4{16'h1111}}};
      mem_m[27'h91] = l;
      @(posedge clk); #1;
      pmem_address = 32'h0000_1234; pmem_read = 1'b1;
      serve(0, l, 32'h0000_1220, 1'b0, lat, nb, cap, rc, wc, aok, lk);
      checks++; if (lat !== 5) begin errors++; $display("FAIL rd_latency got %0d exp 5", lat); end
      checks++; if (!aok) begin errors++; $display("FAIL rd_mem_address got bad exp 00001220"); end
      checks++; if (rc !== 4 || nb !== 4) begin errors++;
         $display("FAIL rd_beats got rd=%0d beats=%0d exp 4/4", rc, nb); end
      checks++; if (pmem_rdata !== l) begin errors++;
         $display("FAIL rd_data got %h exp %h", pmem_rdata, l); end
      @(posedge clk); #1;
      checks++; if (pmem_resp !== 1'b0) begin errors++; $display("FAIL rd_resp_pulse got 1 exp 0"); end
      buf_v = 1'b1; buf_a = 27'h91;
   endtask

   task automatic test_write_gapped();
      int lat, nb, rc, wc, lk; bit aok; logic [255:0] cap, d;
      d = rand_line();
      @(posedge clk); #1;
      pmem_address = 32'h0000_0040; pmem_wdata = d; pmem_write = 1'b1;
      serve(1, rand_line(), 32'h0000_0040, 1'b0, lat, nb, cap, rc, wc, aok, lk);
      checks++; if (cap !== d) begin errors++; $display("FAIL wr_beats_order got %h exp %h", cap, d); end
      checks++; if (nb !== 4 || rc !== 0) begin errors++;
         $display("FAIL wr_beat_count got beats=%0d rd=%0d exp 4/0", nb, rc); end
      checks++; if (wc !== 8) begin errors++; $display("FAIL wr_hold got %0d exp 8", wc); end
      checks++; if (lat !== 9 || !aok) begin errors++;
         $display("FAIL wr_latency_addr got lat=%0d addr_ok=%0d exp 9/1", lat, aok); end
      @(posedge clk); #1;
      checks++; if (pmem_resp !== 1'b0) begin errors++; $display("FAIL wr_resp_pulse got 1 exp 0"); end
      mem_m[27'h2] = d;
      buf_v = 1'b0;
   endtask

   task automatic test_both_high();
      int lat, nb, rc, wc, lk; bit aok; logic [255:0] cap, d;
      d = rand_line();
      @(posedge clk); #1;
      pmem_address = 32'h0000_0208; pmem_wdata = d; pmem_write = 1'b1; pmem_read = 1'b1;
      serve(0, rand_line(), 32'h0000_0200, 1'b1, lat, nb, cap, rc, wc, aok, lk);
      checks++; if (wc !== 4 || rc !== 0 || cap !== d) begin errors++;
         $display("FAIL both_write_first got wr=%0d rd=%0d data=%h exp 4/0/%h", wc, rc, cap, d); end
      checks++; if (lat !== 5) begin errors++; $display("FAIL both_write_latency got %0d exp 5", lat); end
      mem_m[27'h10] = d;
      buf_v = 1'b0;
      serve(0, d, 32'h0000_0200, 1'b0, lat, nb, cap, rc, wc, aok, lk);
      checks++; if (lat !== 6 || rc !== 4 || wc !== 0) begin errors++;
         $display("FAIL both_read_second got lat=%0d rd=%0d wr=%0d exp 6/4/0", lat, rc, wc); end
      checks++; if (pmem_rdata !== d || !aok) begin errors++;
         $display("FAIL both_read_data got %h exp %h", pmem_rdata, d); end
      buf_v = 1'b1; buf_a = 27'h10;
   endtask

   task automatic test_line_buffer();
      int lat, nb, rc, wc, lk, exp_lat; bit aok, hit; logic [255:0] cap, l, d;
      l = get_line(32'h80);
      for (int r = 0; r < 3; r++) begin
         if (r == 2) begin
            d = rand_line();
            @(posedge clk); #1;
            pmem_address = 32'h0000_0100; pmem_wdata = d; pmem_write = 1'b1;
            serve(0, rand_line(), 32'h0000_0100, 1'b0, lat, nb, cap, rc, wc, aok, lk);
            checks++; if (cap !== d || lat !== 5) begin errors++;
               $display("FAIL lb_write got lat=%0d data=%h exp 5/%h", lat, cap, d); end
            mem_m[27'h8] = d;
            buf_v = 1'b0;
         end
         hit = exp_hit(32'h80);
         exp_lat = hit ? 1 : 5;
         @(posedge clk); #1;
         pmem_address = 32'h0000_0080; pmem_read = 1'b1;
         serve(0, l, 32'h0000_0080, 1'b0, lat, nb, cap, rc, wc, aok, lk);
         checks++; if (lat !== exp_lat || rc !== (hit ? 0 : 4)) begin errors++;
            $display("FAIL lb_read%0d got lat=%0d rd=%0d exp %0d/%0d", r, lat, rc, exp_lat, hit ? 0 : 4); end
         checks++; if (pmem_rdata !== l) begin errors++;
            $display("FAIL lb_data%0d got %h exp %h", r, pmem_rdata, l); end
         buf_v = 1'b1; buf_a = 27'h4;
      end
   endtask

   task automatic test_reset_mid_burst();
      int lat, nb, rc, wc, lk; bit aok, quiet; logic [255:0] cap, l;
      l = get_line(32'h600);
      @(posedge clk); #1;
      pmem_address = 32'h0000_0600; pmem_read = 1'b1;
      for (int b = 0; b < 3; b++) begin
         @(posedge clk); #1;
         mem_resp = 1'b1; burst_in = l[b*64 +: 64];
      end
      @(posedge clk); #1;
      mem_resp = 1'b0; rst = 1'b1; pmem_read = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      buf_v = 1'b0;
      checks++; if (mem_read !== 1'b0 || pmem_resp !== 1'b0) begin errors++;
         $display("FAIL rst_mid_ctrl got rd=%b resp=%b exp 0/0", mem_read, pmem_resp); end
      checks++; if (pmem_rdata !== 256'h0) begin errors++;
         $display("FAIL rst_mid_rdata got %h exp 0", pmem_rdata); end
      quiet = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         if (pmem_resp !== 1'b0 || mem_read !== 1'b0) quiet = 1'b0;
      end
      checks++; if (!quiet) begin errors++; $display("FAIL rst_mid_quiet got activity exp none"); end
      pmem_address = 32'h0000_0600; pmem_read = 1'b1;
      serve(0, l, 32'h0000_0600, 1'b0, lat, nb, cap, rc, wc, aok, lk);
      checks++; if (lat !== 5 || nb !== 4 || pmem_rdata !== l) begin errors++;
         $display("FAIL rst_mid_reread got lat=%0d beats=%0d data=%h exp 5/4/%h", lat, nb, pmem_rdata, l); end
      buf_v = 1'b1; buf_a = 27'h30;
   endtask

   task automatic test_stray_resp();
      int lat, nb, rc, wc, lk; bit aok; logic [255:0] cap, l;
      l = get_line(32'h7C0);
      @(posedge clk); #1;
      mem_resp = 1'b1; burst_in = 64'hDEAD_BEEF_0BAD_F00D;
      @(posedge clk); #1;
      burst_in = 64'hFFFF_0000_FFFF_0000;
      @(posedge clk); #1;
      mem_resp = 1'b0;
      pmem_address = 32'h0000_07C4; pmem_read = 1'b1;
      serve(0, l, 32'h0000_07C0, 1'b0, lat, nb, cap, rc, wc, aok, lk);
      checks++; if (nb !== 4 || lat !== 5) begin errors++;
         $display("FAIL stray_beats got beats=%0d lat=%0d exp 4/5", nb, lat); end
      checks++; if (pmem_rdata !== l) begin errors++;
         $display("FAIL stray_data got %h exp %h", pmem_rdata, l); end
      buf_v = 1'b1; buf_a = 27'h3E;
   endtask

   task automatic test_random();
      int lat, nb, rc, wc, lk; bit aok, hit; logic [255:0] cap, l, d; logic [31:0] a, al;
      for (int t = 0; t < 12; t++) begin
         a  = (32'($urandom_range(0, 3)) << 7) | 32'($urandom_range(0, 31));
         al = {a[31:5], 5'b00000};
         @(posedge clk); #1;
         pmem_address = a;
         if ($urandom_range(0, 2) == 0) begin
            d = rand_line();
            pmem_wdata = d; pmem_write = 1'b1;
            serve(2, rand_line(), al, 1'b0, lat, nb, cap, rc, wc, aok, lk);
            checks++; if (cap !== d || nb !== 4 || lat !== lk + 1 || !aok) begin errors++;
               $display("FAIL rand_write%0d got lat=%0d beats=%0d data=%h exp %0d/4/%h",
                        t, lat, nb, cap, lk + 1, d); end
            mem_m[a[31:5]] = d;
            buf_v = 1'b0;
         end else begin
            hit = exp_hit(a);
            l = get_line(a);
            pmem_read = 1'b1;
            serve(2, l, al, 1'b0, lat, nb, cap, rc, wc, aok, lk);
            checks++; if (lat !== lk + 1 || nb !== (hit ? 0 : 4) || !aok) begin errors++;
               $display("FAIL rand_read%0d got lat=%0d beats=%0d exp %0d/%0d",
                        t, lat, nb, lk + 1, hit ? 0 : 4); end
            checks++; if (pmem_rdata !== l) begin errors++;
               $display("FAIL rand_rdata%0d got %h exp %h", t, pmem_rdata, l); end
            buf_v = 1'b1; buf_a = a[31:5];
         end
      end
   endtask

   initial begin
      test_reset();
      test_read_basic();
      test_write_gapped();
      test_both_high();
      test_line_buffer();
      test_reset_mid_burst();
      test_stray_resp();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
